// File: rtl/synth_pkg.sv
// synth_pkg: shared sample-path constants and types for the dac/decimator pair.
package synth_pkg;
   localparam int SAMPLE_W  = 16;
   localparam int DEC_LOG2  = 9;
   localparam int CIC_ORDER = 3;
   typedef logic [15:0] sample_t;
endpackage

// File: rtl/cic_comb.sv
// cic_comb: one CIC comb stage, y = x - x[previous decimated sample].
module cic_comb
   import synth_pkg::*;
#(
   parameter int ACC_W = CIC_ORDER*DEC_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ce,
   input  logic [ACC_W-1:0] x,
   output logic [ACC_W-1:0] y
);
   logic [ACC_W-1:0] r_d;
   always_ff @(posedge clk)
      if (!rstn) r_d <= '0;
      else if (ce) r_d <= x;
   assign y = x - r_d;
endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator: CIC decimator turning the 1-bit PDM stream back into PCM samples.
// Define PDM_DEC_OVF_EN to add the sticky saturation flag output ovf.
module pdm_decimator
   import synth_pkg::*;
#(
   parameter int ORDER  = CIC_ORDER,
   parameter int LOG2_R = DEC_LOG2,
   parameter int OUT_W  = SAMPLE_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             din,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid
`ifdef PDM_DEC_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int ACC_W = ORDER*LOG2_R + 1;
   localparam int SHIFT = ORDER*LOG2_R - OUT_W;
   logic [ACC_W-1:0]  r_integ [ORDER];
   logic [ACC_W-1:0]  w_x [ORDER+1];
   logic [LOG2_R-1:0] r_cnt;
   logic              r_dec;
   logic [OUT_W:0]    w_y;
   logic              w_sat;
   // Integrators update from pre-edge values, so the chain is pipelined.
   always_ff @(posedge clk)
      if (!rstn) begin
         for (int i = 0; i < ORDER; i++) r_integ[i] <= '0;
         r_cnt <= '0;
         r_dec <= 1'b0;
      end else begin
         r_dec <= en && (r_cnt == '1);
         if (en) begin
            r_integ[0] <= r_integ[0] + ACC_W'(din);
            for (int i = 1; i < ORDER; i++) r_integ[i] <= r_integ[i] + r_integ[i-1];
            r_cnt <= r_cnt + 1'b1;
         end
      end
   assign w_x[0] = r_integ[ORDER-1];
   for (genvar k = 0; k < ORDER; k++) begin : g_comb
      cic_comb #(.ACC_W(ACC_W)) u_comb (
         .clk  (clk),
         .rstn (rstn),
         .ce   (r_dec),
         .x    (w_x[k]),
         .y    (w_x[k+1])
      );
   end
   assign w_y   = (OUT_W+1)'(w_x[ORDER] >> SHIFT);
   assign w_sat = w_y[OUT_W];
   always_ff @(posedge clk)
      if (!rstn) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= r_dec;
         if (r_dec) dout <= w_sat ? '1 : w_y[OUT_W-1:0];
      end
`ifdef PDM_DEC_OVF_EN
   always_ff @(posedge clk)
      if (!rstn) ovf <= 1'b0;
      else if (r_dec && w_sat) ovf <= 1'b1;
`endif
endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed checks of the PDM CIC decimator at default parameters.
module tb_pdm_decimator;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic        din = 1'b0;
   logic [15:0] dout;
   logic        dout_valid;
`ifdef PDM_DEC_OVF_EN
   logic        ovf;
`endif
   int errors = 0;
   int checks = 0;
   int en_total = 0;
   int en_prev = 0;

   pdm_decimator dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid)
`ifdef PDM_DEC_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clk = ~clk;

   // en_prev holds the number of en cycles applied before the edge just taken.
   task automatic step(input logic e, input logic d);
      @(negedge clk);
      en = e;
      din = d;
      en_prev = en_total;
      en_total += int'(e);
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rstn = 1'b0;
      en = 1'b1;
      din = 1'b1;
      @(posedge clk);
      #1;
      en_total = 0;
   endtask

   task automatic test_reset();
      hold_reset();
      hold_reset();
      checks++;
      if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0000", dout); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
`ifdef PDM_DEC_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
      rstn = 1'b1;
   endtask

   task automatic test_zeros();
      int pulses = 0;
      hold_reset();
      rstn = 1'b1;
      for (int i = 0; i < 4*512+1; i++) begin
         step(1'b1, 1'b0);
         if (dout_valid) begin
            pulses++;
            checks++;
            if (dout !== 16'h0) begin errors++; $display("FAIL zeros_dout pulse=%0d got=%h exp=0000", pulses, dout); end
            checks++;
            if (en_prev !== 512*pulses) begin errors++; $display("FAIL zeros_spacing pulse=%0d got=%0d exp=%0d", pulses, en_prev, 512*pulses); end
         end
      end
      checks++;
      if (pulses !== 4) begin errors++; $display("FAIL zeros_pulses got=%0d exp=4", pulses); end
   endtask

   task automatic test_ones();
      int pulses = 0;
      hold_reset();
      rstn = 1'b1;
      for (int i = 0; i < 4*512+1; i++) begin
         step(1'b1, 1'b1);
         if (dout_valid) begin
            pulses++;
            if (pulses == 1) begin
               checks++;
               if (dout !== 16'h2A6A) begin errors++; $display("FAIL ones_first got=%h exp=2a6a", dout); end
            end
`ifdef PDM_DEC_OVF_EN
            checks++;
            if (ovf !== (pulses >= 3)) begin errors++; $display("FAIL ones_ovf pulse=%0d got=%b exp=%b", pulses, ovf, pulses >= 3); end
`endif
            if (pulses >= 3) begin
               checks++;
               if (dout !== 16'hFFFF) begin errors++; $display("FAIL ones_dout pulse=%0d got=%h exp=ffff", pulses, dout); end
            end
         end
      end
      checks++;
      if (pulses !== 4) begin errors++; $display("FAIL ones_pulses got=%0d exp=4", pulses); end
   endtask

   task automatic test_alternating();
      int pulses = 0;
      hold_reset();
      rstn = 1'b1;
      for (int i = 0; i < 4*512+1; i++) begin
         step(1'b1, ~i[0]);
         if (dout_valid) begin
            pulses++;
            if (pulses >= 3) begin
               checks++;
               if (dout !== 16'h8000) begin errors++; $display("FAIL alt_dout pulse=%0d got=%h exp=8000", pulses, dout); end
            end
         end
      end
      checks++;
      if (pulses !== 4) begin errors++; $display("FAIL alt_pulses got=%0d exp=4", pulses); end
   endtask

   task automatic test_en_gating();
      int pulses = 0;
      logic ph = 1'b1;
      logic e;
      hold_reset();
      rstn = 1'b1;
      for (int i = 0; i < 8000 && pulses < 4; i++) begin
         e = 1'($urandom_range(0, 1));
         step(e, ph);
         if (e) ph = ~ph;
         if (dout_valid) begin
            pulses++;
            checks++;
            if (en_prev !== 512*pulses) begin errors++; $display("FAIL gate_spacing pulse=%0d got=%0d exp=%0d", pulses, en_prev, 512*pulses); end
            if (pulses >= 3) begin
               checks++;
               if (dout !== 16'h8000) begin errors++; $display("FAIL gate_dout pulse=%0d got=%h exp=8000", pulses, dout); end
            end
         end
      end
      checks++;
      if (pulses !== 4) begin errors++; $display("FAIL gate_pulses got=%0d exp=4", pulses); end
   endtask

   task automatic test_reset_mid();
      logic found = 1'b0;
      hold_reset();
      rstn = 1'b1;
      for (int i = 0; i < 3*512+1+199; i++) step(1'b1, 1'b1);
      checks++;
      if (dout !== 16'hFFFF) begin errors++; $display("FAIL mid_pre_dout got=%h exp=ffff", dout); end
      hold_reset();
      checks++;
      if (dout !== 16'h0) begin errors++; $display("FAIL mid_dout got=%h exp=0000", dout); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", dout_valid); end
`ifdef PDM_DEC_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
`endif
      rstn = 1'b1;
      for (int i = 0; i < 600 && !found; i++) begin
         step(1'b1, 1'b1);
         if (dout_valid) begin
            found = 1'b1;
            checks++;
            if (en_prev !== 512) begin errors++; $display("FAIL mid_latency got=%0d exp=512", en_prev); end
            checks++;
            if (dout !== 16'h2A6A) begin errors++; $display("FAIL mid_first got=%h exp=2a6a", dout); end
         end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL mid_timeout got=0 exp=1"); end
   endtask

   task automatic test_loopback();
      int pulses = 0;
      logic [16:0] acc = '0;
      hold_reset();
      rstn = 1'b1;
      for (int i = 0; i < 19*512 && pulses < 18; i++) begin
         acc = {1'b0, acc[15:0]} + 17'h4000;
         step(1'b1, acc[16]);
         if (dout_valid) begin
            pulses++;
            if (pulses >= 3) begin
               checks++;
               if (dout < 16'h3FFC || dout > 16'h4004) begin errors++; $display("FAIL loop_dout pulse=%0d got=%h exp=4000+-4", pulses, dout); end
            end
         end
      end
      checks++;
      if (pulses !== 18) begin errors++; $display("FAIL loop_pulses got=%0d exp=18", pulses); end
   endtask

   initial begin
      test_reset();
      test_zeros();
      test_ones();
      test_alternating();
      test_en_gating();
      test_reset_mid();
      test_loopback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Receive-side counterpart to the synth's sigma-delta `dac` stage. It takes the 1-bit PDM stream that `dac` produces at the modulator rate and recovers 16-bit PCM samples at the sample rate (20480000/512 = 40000 Hz). It does this with a CIC decimation filter: ORDER integrators, a decimate-by-R counter, and ORDER combs. It is used for loopback self-test on the chip and as the reference decoder in the verification bench.

## Interface
Parameters:
- `ORDER`, default 3: number of CIC integrator/comb stages, range 1–4.
- `LOG2_R`, default 9: log2 of the decimation ratio R (R = 512 by default).
- `OUT_W`, default 16: output sample width. Must satisfy ORDER*LOG2_R ≥ OUT_W.

Ports:
- `clk`, input, 1: modulator clock (20480000 Hz). The block has a single clock domain.
- `rstn`, input, 1: reset, synchronous, active-low.
- `en`, input, 1: input qualifier. `din` is consumed only in cycles where `en` = 1.
- `din`, input, 1: PDM bit. 1 means +full-scale, 0 means zero.
- `dout`, output, OUT_W: decoded sample, unsigned. It holds its value between updates.
- `dout_valid`, output, 1: one-cycle strobe marking each new `dout`.
- `ovf`, output, 1: sticky saturation flag. Present only when `PDM_DEC_OVF_EN` is defined.

## Operation
- Accumulator width is ACC_W = ORDER*LOG2_R + 1 (28 bits at the defaults). All integrators and combs use unsigned modulo-2^ACC_W arithmetic; wrap-around is intended.
- **Integrators.** In each `en` = 1 cycle:
  - I1 += din, zero-extended to ACC_W.
  - Ik += I(k-1) for k = 2..ORDER, using the pre-update value of I(k-1). This is a pipelined chain.
- **Decimation counter.** `cnt` has LOG2_R bits and increments in each `en` cycle, wrapping from R-1 to 0.
  - The decimation instant is an `en` cycle with `cnt` = R-1. Call it the "dec cycle".
- **Combs.** They run only on the cycle after a dec cycle, using the integrator output IORDER as it stands after the dec-cycle update.
  - Ck = x(k-1) − D[k] for k = 1..ORDER, where x0 = IORDER. Then D[k] ← x(k-1).
  - All comb stages are computed combinationally in that one cycle.
- **Scaling and saturation.**
  - y = C_ORDER >> (ORDER*LOG2_R − OUT_W). Range is 0..2^OUT_W.
  - If y = 2^OUT_W, `dout` is forced to 2^OUT_W − 1 (all ones); otherwise `dout` = y[OUT_W-1:0].
- **Startup transient.** The first ORDER−1 valid outputs after reset are transient. Consumers discard them; from output number ORDER onward, `dout` is settled.
- **`en` = 0.** All state is frozen: integrators, `cnt`, and comb delays. `dout_valid` cannot assert except on the cycle after a dec cycle.
- **Reset.** On any clock edge with `rstn` = 0, the following are cleared to 0: all integrators, `cnt`, all comb delays D[k], `dout`, `dout_valid`, and `ovf`. Reset mid-frame discards the partial frame.
- **`en` deasserted on the cycle after a dec cycle.** The comb/output update still happens; it is not gated by `en`.

## Timing
- Reset values:
  - `dout` = 0.
  - `dout_valid` = 0.
  - `ovf` = 0.
- Output latency:
  - `dout` and `dout_valid` update at the clock edge ending the cycle after the dec cycle, i.e. one cycle of latency after the last contributing `din`.
  - `dout_valid` is high for exactly one cycle.
- Output spacing:
  - With `en` tied high, `dout_valid` pulses every R cycles.
  - The first pulse after reset release is the cycle after the R-th `en` cycle.
- Group delay of the filter is ORDER*(R−1)/2 input samples. This is informative only and is not checked cycle-exactly.

## Configuration
- `PDM_DEC_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf` is set in any cycle where saturation forces `dout` to all ones.
  - Once set, it stays set until reset.
- `PDM_DEC_OVF_EN` undefined:
  - The `ovf` port and its logic are absent.
  - Saturation behaviour of `dout` is unchanged.

## Structure
- Shared package `synth_pkg` holds:
  - `SAMPLE_W` = 16,
  - `DEC_LOG2` = 9,
  - `CIC_ORDER` = 3,
  - the typedef `sample_t` (logic [15:0]).

  These are also the defaults for the `dac` input side.
- One sub-module, `cic_comb`: a single comb stage with parameter ACC_W, inputs `clk`, `rstn`, `ce`, `x`, and output `y`.
  - `pdm_decimator` instantiates ORDER copies of `cic_comb` in a generate loop.
  - The integrators and `cnt` are inline in `pdm_decimator`.

## Test plan
- **All zeros.** `din` = 0, `en` = 1 for 4×512 cycles → every `dout_valid` pulse carries `dout` = 0x0000. Pulse spacing is exactly 512 cycles.
- **All ones.** `din` = 1 → settled `dout` = 0xFFFF (saturated). With `PDM_DEC_OVF_EN`, `ovf` = 1 from the first settled output and remains 1.
- **Alternating 1,0,1,0… pattern** → settled `dout` = 0x8000 exactly.
- **`en` gating.**
  - Toggle `en` 50% randomly → `dout_valid` spacing equals 512 `en`-high cycles.
  - With the 1/0 pattern applied on `en` cycles, values match the `en` = 1 case: 0x8000.
- **Reset mid-frame.**
  - Drive `rstn` = 0 for 1 cycle at `cnt` = 200 → `dout` = 0, `dout_valid` = 0, and `ovf` = 0 on the next cycle.
  - The next `dout_valid` follows the 512th `en` cycle after release.
- **Loopback.** `dac` driven with constant 0x4000 feeds `din` → settled `dout` is within 0x4000 ± 4 LSB for 16 consecutive outputs.
